// File: rtl/i2c_slave_ctrl_pkg.sv
// Shared types and constants for the I2C slave controller.
// The address-match helper keeps the general-call rule in one place.
package i2c_slave_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ACK_ADDR  = 3'd2,
        RX        = 3'd3,
        RX_ACK    = 3'd4,
        TX        = 3'd5,
        MACK      = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_slave_state_t;

    localparam logic [6:0] I2C_GCALL_ADDR = 7'h00;
    localparam logic       I2C_ACK        = 1'b0;
    localparam logic       I2C_NACK       = 1'b1;

    // General call is only honoured as a write.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own_addr,
                                        input logic       gcall_en);
        logic own_hit;
        logic gcall_hit;
        own_hit   = (addr_byte[7:1] == own_addr);
        gcall_hit = gcall_en && (addr_byte[7:1] == I2C_GCALL_ADDR) && (addr_byte[0] == 1'b0);
        return own_hit || gcall_hit;
    endfunction

endpackage

// File: rtl/i2c_slave_ctrl_bit_shifter.sv
// Byte shifter for the I2C slave: serial in on SCL rise, serial out on SCL fall,
// parallel load for transmit, and a 3-bit bit counter with a last-bit flag.
module i2c_bit_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       shift_in_i,
    input  logic       shift_out_i,
    input  logic       sda_i,
    output logic [7:0] next_byte_o,
    output logic       next_tx_bit_o,
    output logic       last_bit_o
);

    logic [7:0] sreg_q;
    logic [7:0] sreg_d;
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            sreg_d = 8'h00;
            cnt_d  = 3'd0;
        end else if (load_i) begin
            sreg_d = load_data_i;
            cnt_d  = 3'd0;
        end else if (shift_out_i) begin
            sreg_d = {sreg_q[6:0], 1'b0};
            cnt_d  = cnt_q + 3'd1;
        end else if (shift_in_i) begin
            sreg_d = {sreg_q[6:0], sda_i};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= 8'h00;
            cnt_q  <= 3'd0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    // The byte as it will look once the bit arriving this cycle is shifted in.
    assign next_byte_o   = {sreg_q[6:0], sda_i};
    assign next_tx_bit_o = sreg_q[6];
    assign last_bit_o    = (cnt_q == 3'd7);

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave controller: address match, write reception with byte limit,
// read transmission with master ACK handling, and SDA pull-down generation.
module i2c_slave_ctrl
    import i2c_slave_ctrl_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         MAX_BYTES  = 4,
    parameter bit         GCALL_EN   = 1'b0,
    parameter int         CNT_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             scl_rise_in,
    input  logic             scl_fall_in,
    input  logic             sda_in,
    input  logic [7:0]       tx_data_in,
    output logic [7:0]       rx_data_out,
    output logic             rx_valid_out,
    output logic             tx_req_out,
    output logic             rw_out,
    output logic             busy_out,
    output logic [CNT_W-1:0] byte_cnt_out,
    output logic             sda_oe_out,
    output logic             frame_err_out
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    i2c_slave_state_t state_q, state_d;
    logic             rw_q, rw_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             sda_oe_q, sda_oe_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_req_q, tx_req_d;
    logic             frame_err_q, frame_err_d;

    logic       fall_ev;
    logic       rise_ev;
    logic       shift_in_en;
    logic       shift_out_en;
    logic       load_en;
    logic [7:0] next_byte;
    logic       next_tx_bit;
    logic       last_bit;

    // Bus events are mutually exclusive in priority order stop > start > fall > rise.
    assign fall_ev = scl_fall_in & ~start_in & ~stop_in;
    assign rise_ev = scl_rise_in & ~scl_fall_in & ~start_in & ~stop_in;

    assign shift_in_en  = rise_ev & ~pend_q & ((state_q == ADDR) | (state_q == RX));
    assign shift_out_en = fall_ev & (state_q == TX);
    assign load_en      = fall_ev & (((state_q == ACK_ADDR) & rw_q) | ((state_q == MACK) & pend_q));

    i2c_bit_shifter u_shifter (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (start_in | stop_in),
        .load_i        (load_en),
        .load_data_i   (tx_data_in),
        .shift_in_i    (shift_in_en),
        .shift_out_i   (shift_out_en),
        .sda_i         (sda_in),
        .next_byte_o   (next_byte),
        .next_tx_bit_o (next_tx_bit),
        .last_bit_o    (last_bit)
    );

    // pend_q marks "byte complete, ACK/reload due at the next SCL fall".
    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        pend_d      = pend_q;
        byte_cnt_d  = byte_cnt_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        frame_err_d = 1'b0;

        if (stop_in) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            pend_d   = 1'b0;
        end else if (start_in) begin
            state_d    = ADDR;
            sda_oe_d   = 1'b0;
            pend_d     = 1'b0;
            byte_cnt_d = '0;
            rw_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR: begin
                    if (fall_ev && pend_q) begin
                        sda_oe_d = ~I2C_ACK;
                        pend_d   = 1'b0;
                        state_d  = ACK_ADDR;
                    end else if (shift_in_en && last_bit) begin
                        if (addr_match(next_byte, SLAVE_ADDR, GCALL_EN)) begin
                            rw_d   = next_byte[0];
                            pend_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (fall_ev) begin
                        if (rw_q) begin
                            sda_oe_d = ~tx_data_in[7];
                            tx_req_d = 1'b1;
                            state_d  = TX;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = RX;
                        end
                    end
                end
                RX: begin
                    if (fall_ev && pend_q) begin
                        sda_oe_d = ~I2C_ACK;
                        pend_d   = 1'b0;
                        state_d  = RX_ACK;
                    end else if (shift_in_en && last_bit) begin
                        rx_data_d  = next_byte;
                        rx_valid_d = 1'b1;
                        if (byte_cnt_q < MAX_CNT) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            pend_d     = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = WAIT_STOP;
                        end
                    end
                end
                RX_ACK: begin
                    if (fall_ev) begin
                        sda_oe_d = 1'b0;
                        state_d  = RX;
                    end
                end
                TX: begin
                    if (fall_ev) begin
                        if (last_bit) begin
                            sda_oe_d = 1'b0;
                            state_d  = MACK;
                        end else begin
                            sda_oe_d = ~next_tx_bit;
                        end
                    end
                end
                MACK: begin
                    if (fall_ev && pend_q) begin
                        sda_oe_d = ~tx_data_in[7];
                        tx_req_d = 1'b1;
                        pend_d   = 1'b0;
                        state_d  = TX;
                    end else if (rise_ev && !pend_q) begin
                        if (sda_in == I2C_ACK) begin
                            if (byte_cnt_q != MAX_CNT) begin
                                byte_cnt_d = byte_cnt_q + 1'b1;
                            end
                            pend_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                    pend_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            pend_q      <= 1'b0;
            byte_cnt_q  <= '0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            pend_q      <= pend_d;
            byte_cnt_q  <= byte_cnt_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data_out   = rx_data_q;
    assign rx_valid_out  = rx_valid_q;
    assign tx_req_out    = tx_req_q;
    assign rw_out        = rw_q;
    assign busy_out      = (state_q == ACK_ADDR) || (state_q == RX) || (state_q == RX_ACK) ||
                           (state_q == TX) || (state_q == MACK);
    assign byte_cnt_out  = byte_cnt_q;
    assign sda_oe_out    = sda_oe_q;
    assign frame_err_out = frame_err_q;

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
Parametrised next-generation I2C slave controller.
- Replaces the fixed-behaviour control FSM plus external counters and comparators with one self-contained block.
- Internal bit counter, shift register, address compare, byte counter, ACK/NACK generation and read (slave-transmit) support.
- Placement: downstream of the START/STOP and SCL-edge detectors; upstream of the filter register file and data path.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit slave address matched against the address byte
MAX_BYTES, 4, data bytes accepted per write frame; later bytes are NACKed
GCALL_EN, 0, 1 = also acknowledge general-call address 7'h00 (write only)
CNT_W, $clog2(MAX_BYTES+1), width of byte counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_in  in  1  1-cycle pulse: START or repeated START detected
stop_in  in  1  1-cycle pulse: STOP detected
scl_rise_in  in  1  1-cycle pulse: SCL rising edge
scl_fall_in  in  1  1-cycle pulse: SCL falling edge
sda_in  in  1  synchronised SDA level
tx_data_in  in  8  byte to transmit in read frames
rx_data_out  out  8  last received data byte
rx_valid_out  out  1  1-cycle pulse: rx_data_out updated
tx_req_out  out  1  1-cycle pulse: next tx byte requested
rw_out  out  1  R/W bit of the current frame (1 = read)
busy_out  out  1  1 while addressed (ACK_ADDR through end of frame)
byte_cnt_out  out  CNT_W  data bytes handled in current frame
sda_oe_out  out  1  1 = pull SDA low
frame_err_out  out  1  1-cycle pulse: overflow NACK issued

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- On rst: state IDLE; all outputs 0; sda_oe_out released; shift register, bit counter and byte counter cleared. Reset mid-frame aborts the frame silently.
- Bit timing: SDA sampled on scl_rise_in, MSB first. sda_oe_out changes only on scl_fall_in, registered the cycle after the pulse.
- Event priority in one cycle: stop_in > start_in > scl_fall_in > scl_rise_in.
  - stop_in from any state -> IDLE.
  - start_in from any state -> ADDR; counters cleared; sda released.
- States:
  - IDLE: wait for start_in.
  - ADDR: shift 8 bits. After the 8th rise, compare bits[7:1] with SLAVE_ADDR, or with 7'h00 when GCALL_EN=1 and bit0=0.
    - Match: latch rw_out; at the next fall drive ACK (sda_oe=1) and go to ACK_ADDR.
    - Miss: go to WAIT_STOP; sda never driven.
  - ACK_ADDR: at the next fall, release sda.
    - Write: go to RX.
    - Read: load tx_data_in into the shifter, drive its MSB (sda_oe = ~bit), pulse tx_req_out the following cycle, go to TX.
  - RX: shift 8 bits. At the 8th rise, rx_data_out <= shifter and rx_valid_out pulses one cycle.
    - byte_cnt < MAX_BYTES: increment byte_cnt; at the next fall drive ACK; go to RX_ACK.
    - Otherwise: no ACK (NACK), frame_err_out pulses, go to WAIT_STOP.
  - RX_ACK: at the next fall, release sda; go to RX.
  - TX: on each fall, drive the next bit. At the fall after the 8th bit, release sda and go to MACK.
  - MACK: sample the master ack at the rise.
    - sda_in=0: byte_cnt increments, saturating at MAX_BYTES (no overflow limit on reads). At the next fall, reload tx_data_in, drive its MSB, pulse tx_req_out, go to TX.
    - sda_in=1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: idle, sda released; leave only via stop_in or start_in.
- busy_out = 1 in ACK_ADDR, RX, RX_ACK, TX, MACK.
- byte_cnt_out holds its value in IDLE until the next START.

Decomposition:
- myfilter_pkg additions:
  - i2c_slave_state_t enum: IDLE, ADDR, ACK_ADDR, RX, RX_ACK, TX, MACK, WAIT_STOP.
  - Constants I2C_GCALL_ADDR = 7'h00, I2C_ACK = 1'b0, I2C_NACK = 1'b1.
- One sub-module, i2c_bit_shifter:
  - 8-bit shift register with load, shift-in on rise and shift-out on fall.
  - 3-bit counter with last-bit flag.
- The FSM, address compare and byte counter stay in i2c_slave_ctrl.

Test Plan:
- Write frame addr 0x42/W, data 0xA5, 0x3C, STOP -> ACK on all 3 ack slots; rx_valid pulses with 0xA5 then 0x3C; byte_cnt=2; busy drops at STOP.
- Address 0x17/W -> sda_oe never asserted; state WAIT_STOP until STOP; no rx_valid.
- Write 5 bytes with MAX_BYTES=4 -> bytes 1-4 ACKed; 5th NACKed; frame_err pulses once; byte_cnt=4.
- Read 0x42/R with tx_data_in 0x96 then 0x0F, master ACK then NACK -> SDA shows 1001_0110, 0000_1111; tx_req pulses twice; then WAIT_STOP.
- Repeated START mid write byte (after 3 bits) -> counters cleared; new address phase ACKed; no rx_valid for the partial byte.
- GCALL_EN=1: addr 0x00/W ACKed; addr 0x00/R not ACKed. rst asserted mid-RX -> all outputs 0 next cycle.
